// File: rtl/ikbd_acia.sv
// ikbd_acia: 6850-style ACIA at the host end of the keyboard serial link.
// Fixed 8N1 framing at BIT_CLKS clocks per bit. Two-flop synchronisers on
// rxd/cts_n. Separate RX and TX state machines. Combinational read mux.
module ikbd_acia #(
  parameter int BIT_CLKS = 512
) (
  input  logic       mcu_clx2,
  input  logic       mcu_rst_n,
  input  logic       cs,
  input  logic       rs,
  input  logic       wr,
  input  logic       rd,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       irq_n,
  input  logic       rxd,
  output logic       txd,
  input  logic       cts_n,
  output logic       rts_n
);

  localparam int CW = $clog2(BIT_CLKS) + 1;
  localparam logic [CW-1:0] C_FULL = CW'(BIT_CLKS - 1);
  localparam logic [CW-1:0] C_HALF = CW'(BIT_CLKS / 2 - 1);
  localparam logic [CW-1:0] C_ONE  = CW'(1);
  localparam logic [CW-1:0] C_ZERO = {CW{1'b0}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // The word-select bits CR4:2 are not kept: the frame is always 8N1, so they
  // can never change behaviour and are not readable.
  logic [1:0]    r_cr_div;
  logic [1:0]    r_cr_tc;
  logic          r_cr_rie;
  logic          r_rts_n;
  logic          r_rxd_m, r_rxd_s, r_rxd_d;
  logic          r_cts_m, r_cts_s;
  logic [7:0]    r_rdr;
  logic          r_rdrf, r_fe, r_ovrn;
  state_t        r_rx_state, w_rx_state_nx;
  logic [CW-1:0] r_rx_cnt, w_rx_cnt_nx;
  logic [2:0]    r_rx_bit, w_rx_bit_nx;
  logic [7:0]    r_rx_shift, w_rx_shift_nx;
  logic          w_rx_done;
  logic [7:0]    r_tdr;
  logic          r_tdre;
  state_t        r_tx_state, w_tx_state_nx;
  logic [CW-1:0] r_tx_cnt, w_tx_cnt_nx;
  logic [2:0]    r_tx_bit, w_tx_bit_nx;
  logic [7:0]    r_tx_shift, w_tx_shift_nx;
  logic          r_tx_line, w_tx_line_nx;
  logic          w_tx_load;
  logic          r_txd;

  logic w_mreset, w_cr_wr, w_tdr_wr, w_rdr_rd, w_rx_fall;
  logic w_rx_tick, w_tx_tick, w_tx_go, w_irq;

  assign w_mreset  = (r_cr_div == 2'b11);
  assign w_cr_wr   = cs & wr & ~rs;
  assign w_tdr_wr  = cs & wr & rs & ~w_mreset;
  assign w_rdr_rd  = cs & rd & rs;
  assign w_rx_fall = r_rxd_d & ~r_rxd_s;
  assign w_rx_tick = (r_rx_cnt == C_ZERO);
  assign w_tx_tick = (r_tx_cnt == C_ZERO);
  assign w_tx_go   = ~r_tdre & ~r_cts_s;
  assign w_irq     = (r_cr_rie & (r_rdrf | r_ovrn)) |
                     ((r_cr_tc == 2'b01) & r_tdre & ~r_cts_s);

  assign irq_n = ~w_irq;
  assign rts_n = r_rts_n;
  assign txd   = r_txd;
  assign dout  = rs ? r_rdr
                    : {w_irq, 1'b0, r_ovrn, r_fe, r_cts_s, 1'b0, r_tdre & ~r_cts_s, r_rdrf};

  // Control register and the registered rts_n decode.
  always_ff @(posedge mcu_clx2 or negedge mcu_rst_n) begin
    if (!mcu_rst_n) begin
      r_cr_div <= 2'b11;
      r_cr_tc  <= 2'b00;
      r_cr_rie <= 1'b0;
      r_rts_n  <= 1'b0;
    end else begin
      if (w_cr_wr) begin
        r_cr_div <= din[1:0];
        r_cr_tc  <= din[6:5];
        r_cr_rie <= din[7];
      end
      r_rts_n <= (r_cr_tc == 2'b10);
    end
  end

  // Two-flop synchronisers for rxd and cts_n, plus the previous rxd for edge detect.
  always_ff @(posedge mcu_clx2 or negedge mcu_rst_n) begin
    if (!mcu_rst_n) begin
      r_rxd_m <= 1'b1;
      r_rxd_s <= 1'b1;
      r_rxd_d <= 1'b1;
      r_cts_m <= 1'b0;
      r_cts_s <= 1'b0;
    end else begin
      r_rxd_m <= rxd;
      r_rxd_s <= r_rxd_m;
      r_rxd_d <= r_rxd_s;
      r_cts_m <= cts_n;
      r_cts_s <= r_cts_m;
    end
  end

  // RX next-state: half-bit start check, then whole-bit spaced samples.
  always_comb begin
    w_rx_state_nx = r_rx_state;
    w_rx_cnt_nx   = r_rx_cnt;
    w_rx_bit_nx   = r_rx_bit;
    w_rx_shift_nx = r_rx_shift;
    w_rx_done     = 1'b0;
    if (w_mreset) begin
      w_rx_state_nx = S_IDLE;
    end else begin
      case (r_rx_state)
        S_IDLE: begin
          if (w_rx_fall) begin
            w_rx_state_nx = S_START;
            w_rx_cnt_nx   = C_HALF;
          end else begin
            w_rx_state_nx = S_IDLE;
          end
        end
        S_START: begin
          if (w_rx_tick) begin
            w_rx_state_nx = r_rxd_s ? S_IDLE : S_DATA;
            w_rx_cnt_nx   = C_FULL;
            w_rx_bit_nx   = 3'd0;
          end else begin
            w_rx_cnt_nx = r_rx_cnt - C_ONE;
          end
        end
        S_DATA: begin
          if (w_rx_tick) begin
            w_rx_shift_nx = {r_rxd_s, r_rx_shift[7:1]};
            w_rx_cnt_nx   = C_FULL;
            w_rx_bit_nx   = r_rx_bit + 3'd1;
            w_rx_state_nx = (r_rx_bit == 3'd7) ? S_STOP : S_DATA;
          end else begin
            w_rx_cnt_nx = r_rx_cnt - C_ONE;
          end
        end
        S_STOP: begin
          if (w_rx_tick) begin
            w_rx_done     = 1'b1;
            w_rx_state_nx = S_IDLE;
          end else begin
            w_rx_cnt_nx = r_rx_cnt - C_ONE;
          end
        end
        default: w_rx_state_nx = S_IDLE;
      endcase
    end
  end

  // RX state register.
  always_ff @(posedge mcu_clx2 or negedge mcu_rst_n) begin
    if (!mcu_rst_n) begin
      r_rx_state <= S_IDLE;
      r_rx_cnt   <= C_ZERO;
      r_rx_bit   <= 3'd0;
      r_rx_shift <= 8'h00;
    end else begin
      r_rx_state <= w_rx_state_nx;
      r_rx_cnt   <= w_rx_cnt_nx;
      r_rx_bit   <= w_rx_bit_nx;
      r_rx_shift <= w_rx_shift_nx;
    end
  end

  // Receive flags and RDR; a transfer coinciding with an RDR read takes the new byte.
  always_ff @(posedge mcu_clx2 or negedge mcu_rst_n) begin
    if (!mcu_rst_n) begin
      r_rdr  <= 8'h00;
      r_rdrf <= 1'b0;
      r_fe   <= 1'b0;
      r_ovrn <= 1'b0;
    end else if (w_mreset) begin
      r_rdrf <= 1'b0;
      r_fe   <= 1'b0;
      r_ovrn <= 1'b0;
    end else if (w_rx_done) begin
      if (!r_rdrf || w_rdr_rd) begin
        r_rdr  <= r_rx_shift;
        r_rdrf <= 1'b1;
        r_fe   <= ~r_rxd_s;
        r_ovrn <= 1'b0;
      end else begin
        r_ovrn <= 1'b1;
      end
    end else if (w_rdr_rd) begin
      r_rdrf <= 1'b0;
      r_fe   <= 1'b0;
      r_ovrn <= 1'b0;
    end else begin
      r_rdrf <= r_rdrf;
    end
  end

  // TX next-state: a pending byte loads straight from the stop bit, so frames abut.
  always_comb begin
    w_tx_state_nx = r_tx_state;
    w_tx_cnt_nx   = r_tx_cnt;
    w_tx_bit_nx   = r_tx_bit;
    w_tx_shift_nx = r_tx_shift;
    w_tx_line_nx  = r_tx_line;
    w_tx_load     = 1'b0;
    if (w_mreset) begin
      w_tx_state_nx = S_IDLE;
      w_tx_line_nx  = 1'b1;
    end else begin
      case (r_tx_state)
        S_IDLE: begin
          if (w_tx_go) begin
            w_tx_load     = 1'b1;
            w_tx_shift_nx = r_tdr;
            w_tx_line_nx  = 1'b0;
            w_tx_state_nx = S_START;
            w_tx_cnt_nx   = C_FULL;
          end else begin
            w_tx_line_nx = 1'b1;
          end
        end
        S_START: begin
          if (w_tx_tick) begin
            w_tx_line_nx  = r_tx_shift[0];
            w_tx_shift_nx = {1'b0, r_tx_shift[7:1]};
            w_tx_bit_nx   = 3'd0;
            w_tx_state_nx = S_DATA;
            w_tx_cnt_nx   = C_FULL;
          end else begin
            w_tx_cnt_nx = r_tx_cnt - C_ONE;
          end
        end
        S_DATA: begin
          if (w_tx_tick) begin
            w_tx_cnt_nx = C_FULL;
            if (r_tx_bit == 3'd7) begin
              w_tx_line_nx  = 1'b1;
              w_tx_state_nx = S_STOP;
            end else begin
              w_tx_line_nx  = r_tx_shift[0];
              w_tx_shift_nx = {1'b0, r_tx_shift[7:1]};
              w_tx_bit_nx   = r_tx_bit + 3'd1;
            end
          end else begin
            w_tx_cnt_nx = r_tx_cnt - C_ONE;
          end
        end
        S_STOP: begin
          if (w_tx_tick && w_tx_go) begin
            w_tx_load     = 1'b1;
            w_tx_shift_nx = r_tdr;
            w_tx_line_nx  = 1'b0;
            w_tx_state_nx = S_START;
            w_tx_cnt_nx   = C_FULL;
          end else if (w_tx_tick) begin
            w_tx_line_nx  = 1'b1;
            w_tx_state_nx = S_IDLE;
          end else begin
            w_tx_cnt_nx = r_tx_cnt - C_ONE;
          end
        end
        default: begin
          w_tx_state_nx = S_IDLE;
          w_tx_line_nx  = 1'b1;
        end
      endcase
    end
  end

  // TX state register; txd is the FSM line gated by break, forced high in master reset.
  always_ff @(posedge mcu_clx2 or negedge mcu_rst_n) begin
    if (!mcu_rst_n) begin
      r_tx_state <= S_IDLE;
      r_tx_cnt   <= C_ZERO;
      r_tx_bit   <= 3'd0;
      r_tx_shift <= 8'h00;
      r_tx_line  <= 1'b1;
      r_txd      <= 1'b1;
    end else begin
      r_tx_state <= w_tx_state_nx;
      r_tx_cnt   <= w_tx_cnt_nx;
      r_tx_bit   <= w_tx_bit_nx;
      r_tx_shift <= w_tx_shift_nx;
      r_tx_line  <= w_tx_line_nx;
      r_txd      <= w_mreset | (w_tx_line_nx & (r_cr_tc != 2'b11));
    end
  end

  // TDR and TDRE: a host write wins over a same-cycle shifter load.
  always_ff @(posedge mcu_clx2 or negedge mcu_rst_n) begin
    if (!mcu_rst_n) begin
      r_tdr  <= 8'h00;
      r_tdre <= 1'b1;
    end else if (w_mreset) begin
      r_tdre <= 1'b1;
    end else if (w_tdr_wr) begin
      r_tdr  <= din;
      r_tdre <= 1'b0;
    end else if (w_tx_load) begin
      r_tdre <= 1'b1;
    end else begin
      r_tdre <= r_tdre;
    end
  end

endmodule

// File: tb/tb_ikbd_acia.sv
// tb_ikbd_acia: self-checking bench for ikbd_acia with BIT_CLKS = 16.
module tb_ikbd_acia;

  localparam int BC = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cs, rs, wr, rd;
  logic [7:0] din;
  logic [7:0] dout;
  logic       irq_n, rxd, txd, cts_n, rts_n;

  int checks = 0;
  int errors = 0;

  // Behavioural receive model: what the host should see after each frame.
  logic       m_rdrf, m_fe, m_ovrn;
  logic [7:0] m_rdr;
  logic [7:0] q[$];

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic [7:0] exp_status;
    logic [7:0] exp_rdr;
  } rxvec_t;
  rxvec_t vecs[5];

  ikbd_acia #(.BIT_CLKS(BC)) dut (
    .mcu_clx2 (clk),
    .mcu_rst_n(rst_n),
    .cs       (cs),
    .rs       (rs),
    .wr       (wr),
    .rd       (rd),
    .din      (din),
    .dout     (dout),
    .irq_n    (irq_n),
    .rxd      (rxd),
    .txd      (txd),
    .cts_n    (cts_n),
    .rts_n    (rts_n)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_wr(input logic sel, input logic [7:0] d);
    cs = 1'b1; wr = 1'b1; rs = sel; din = d;
    tick();
    cs = 1'b0; wr = 1'b0;
  endtask

  task automatic get_status(output logic [7:0] s);
    rs = 1'b0;
    #1;
    s = dout;
  endtask

  task automatic rd_rdr(output logic [7:0] d);
    rs = 1'b1;
    #1;
    d = dout;
    cs = 1'b1; rd = 1'b1;
    tick();
    cs = 1'b0; rd = 1'b0;
  endtask

  // Drive one 8N1 frame on rxd, then one bit time of idle line.
  task automatic send_rx(input logic [7:0] b, input logic stop, input logic timing);
    logic [9:0] f;
    logic [7:0] s;
    f = {stop, b, 1'b0};
    for (int k = 0; k < 10 * BC; k++) begin
      rxd = f[k / BC];
      tick();
      if (timing && k == 153) begin
        get_status(s);
        chk("rx_rdrf_before_stop_sample", s[0], 1'b0);
      end
      if (timing && k == 154) begin
        get_status(s);
        chk("rx_rdrf_after_stop_sample", s[0], 1'b1);
        chk("rx_irq_n_after_stop_sample", irq_n, 1'b0);
      end
    end
    rxd = 1'b1;
    repeat (BC) tick();
  endtask

  // Called just after the load edge; checks every clock of the frame.
  task automatic tx_check(input logic [7:0] b, input int cts_at);
    logic [9:0] f;
    int bad;
    f = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      bad = 0;
      for (int j = 0; j < BC; j++) begin
        if (i != 0 || j != 0) tick();
        if (i * BC + j == cts_at) cts_n = 1'b1;
        if (txd !== f[i]) bad++;
      end
      chk($sformatf("tx_bit%0d_bad_clocks", i), bad, 0);
    end
    tick();
    chk("tx_idle_after_frame", txd, 1'b1);
  endtask

  initial begin
    logic [7:0] s, v, b, got;
    logic [9:0] f;
    logic       stb, sb, stp, found;
    int         bad, lat;

    vecs[0] = '{8'h3C, 1'b1, 8'h83, 8'h3C};
    vecs[1] = '{8'h00, 1'b1, 8'h83, 8'h00};
    vecs[2] = '{8'hFF, 1'b1, 8'h83, 8'hFF};
    vecs[3] = '{8'hA5, 1'b0, 8'h93, 8'hA5};
    vecs[4] = '{8'h80, 1'b1, 8'h83, 8'h80};
    m_rdrf = 1'b0; m_fe = 1'b0; m_ovrn = 1'b0; m_rdr = 8'h00;

    // Reset
    cs = 1'b0; rs = 1'b0; wr = 1'b0; rd = 1'b0; din = 8'h00;
    rxd = 1'b1; cts_n = 1'b0; rst_n = 1'b0;
    repeat (3) tick();
    chk("reset_txd_during", txd, 1'b1);
    chk("reset_irq_n_during", irq_n, 1'b1);
    rst_n = 1'b1;
    repeat (3) tick();
    get_status(s);
    chk("reset_status", s, 8'h02);
    chk("reset_txd", txd, 1'b1);
    chk("reset_irq_n", irq_n, 1'b1);
    chk("reset_rts_n", rts_n, 1'b0);
    rs = 1'b1; #1;
    chk("reset_rdr", dout, 8'h00);

    // Transmit-control modes: rts_n, TX irq, break
    cpu_wr(1'b0, 8'h55);
    chk("rts_n_same_clock", rts_n, 1'b0);
    tick();
    chk("rts_n_mode10", rts_n, 1'b1);
    cpu_wr(1'b0, 8'h35);
    chk("tx_irq_n_mode01", irq_n, 1'b0);
    get_status(s);
    chk("status_mode01", s, 8'h82);
    tick();
    chk("rts_n_mode01", rts_n, 1'b0);
    cpu_wr(1'b0, 8'h75);
    tick();
    chk("break_txd", txd, 1'b0);
    chk("break_irq_n", irq_n, 1'b1);
    cpu_wr(1'b0, 8'h15);
    tick();
    chk("break_release_txd", txd, 1'b1);

    // Transmit A5
    cpu_wr(1'b1, 8'hA5);
    get_status(s);
    chk("tdre_after_write", s[1], 1'b0);
    tick();
    get_status(s);
    chk("tdre_after_load", s[1], 1'b1);
    tx_check(8'hA5, -1);

    // Receive table
    cpu_wr(1'b0, 8'h95);
    for (int i = 0; i < 5; i++) begin
      send_rx(vecs[i].data, vecs[i].stop, (i == 0));
      get_status(s);
      chk($sformatf("rxvec%0d_status", i), s, vecs[i].exp_status);
      rd_rdr(v);
      chk($sformatf("rxvec%0d_rdr", i), v, vecs[i].exp_rdr);
      get_status(s);
      chk($sformatf("rxvec%0d_status_after_read", i), s, 8'h02);
      chk($sformatf("rxvec%0d_irq_n_after_read", i), irq_n, 1'b1);
    end

    // Overrun and framing
    send_rx(8'h11, 1'b0, 1'b0);
    send_rx(8'h22, 1'b1, 1'b0);
    get_status(s);
    chk("ovrn_status", s, 8'hB3);
    chk("ovrn_irq_n", irq_n, 1'b0);
    rd_rdr(v);
    chk("ovrn_rdr_first_byte", v, 8'h11);
    get_status(s);
    chk("ovrn_status_cleared", s, 8'h02);
    chk("ovrn_irq_n_cleared", irq_n, 1'b1);

    // CTS gating
    cts_n = 1'b1;
    repeat (3) tick();
    cpu_wr(1'b1, 8'h55);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (txd !== 1'b1) bad++;
    end
    chk("cts_blocked_txd_bad_clocks", bad, 0);
    get_status(s);
    chk("cts_blocked_status", s, 8'h08);
    cts_n = 1'b0;
    found = 1'b0; lat = 0;
    for (int i = 0; i < 4 && !found; i++) begin
      tick();
      if (txd === 1'b0) begin
        found = 1'b1;
        lat = i + 1;
      end
    end
    chk("cts_start_found", found, 1'b1);
    chk("cts_start_within_3", (lat <= 3), 1'b1);
    if (found) tx_check(8'h55, 40);
    get_status(s);
    chk("cts_high_after_frame_status", s, 8'h08);
    cts_n = 1'b0;
    repeat (3) tick();

    // Random back-to-back transmit against a byte queue
    b = 8'($urandom);
    q.push_back(b);
    cpu_wr(1'b1, b);
    tick();
    chk("rtx_first_start", txd, 1'b0);
    for (int n = 0; n < 6; n++) begin
      got = 8'h00; stb = 1'b1; sb = 1'b0;
      for (int k = 0; k < 10 * BC; k++) begin
        if (k == 8) stb = txd;
        if (k >= 24 && k < 152 && ((k - 24) % BC) == 0) got[(k - 24) / BC] = txd;
        if (k == 152) sb = txd;
        if (k == 40 && n < 5) begin
          b = 8'($urandom);
          q.push_back(b);
          cs = 1'b1; wr = 1'b1; rs = 1'b1; din = b;
        end
        if (k == 41) begin
          cs = 1'b0; wr = 1'b0;
        end
        tick();
      end
      chk("rtx_start_bit", stb, 1'b0);
      chk("rtx_data", got, q.pop_front());
      chk("rtx_stop_bit", sb, 1'b1);
      if (n < 5) chk("rtx_no_gap", txd, 1'b0);
      else       chk("rtx_idle", txd, 1'b1);
    end

    // Random receive against the flag model, with random reads
    for (int n = 0; n < 8; n++) begin
      b = 8'($urandom);
      stp = ($urandom_range(0, 3) != 0);
      send_rx(b, stp, 1'b0);
      if (!m_rdrf) begin
        m_rdr = b; m_rdrf = 1'b1; m_fe = ~stp;
      end else begin
        m_ovrn = 1'b1;
      end
      get_status(s);
      chk("rrx_status", s, {m_rdrf | m_ovrn, 1'b0, m_ovrn, m_fe, 1'b0, 1'b0, 1'b1, m_rdrf});
      if ($urandom_range(0, 1) == 1 || n == 7) begin
        rd_rdr(v);
        chk("rrx_rdr", v, m_rdr);
        m_rdrf = 1'b0; m_fe = 1'b0; m_ovrn = 1'b0;
      end
    end

    // Master reset mid-TX and mid-RX
    cpu_wr(1'b1, 8'h2A);
    tick();
    chk("mr_tx_started", txd, 1'b0);
    f = {1'b1, 8'hC3, 1'b0};
    bad = 0;
    for (int k = 0; k < 240; k++) begin
      rxd = (k < 10 * BC) ? f[k / BC] : 1'b1;
      if (k == 85) begin
        chk("mr_tx_bit4_before", txd, 1'b0);
        cs = 1'b1; wr = 1'b1; rs = 1'b0; din = 8'h03;
      end
      if (k == 86) begin
        cs = 1'b0; wr = 1'b0;
      end
      tick();
      if (k == 86) chk("mr_txd_next_clock", txd, 1'b1);
      if (k > 86 && txd !== 1'b1) bad++;
    end
    chk("mr_txd_held_bad_clocks", bad, 0);
    get_status(s);
    chk("mr_status", s, 8'h02);
    chk("mr_irq_n", irq_n, 1'b1);
    rs = 1'b1; #1;
    chk("mr_rdr_kept", dout, m_rdr);
    cpu_wr(1'b1, 8'h77);
    repeat (3) tick();
    get_status(s);
    chk("mr_tdr_write_ignored", s, 8'h02);
    cpu_wr(1'b0, 8'h95);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (txd !== 1'b1) bad++;
    end
    chk("mr_release_no_tx_bad_clocks", bad, 0);
    get_status(s);
    chk("mr_release_status", s, 8'h02);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
